// File: rtl/reg_file.sv
// 32-entry integer register file: two combinational read ports decoded from the instruction, one write port.
// Define REG_FILE_BYPASS_EN to forward a same-cycle write onto matching read ports.
module reg_file #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instruction,
  input  logic            reg_write,
  input  logic [4:0]      write_addr,
  input  logic [XLEN-1:0] write_data,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2
);

  localparam int unsigned AW = 5;

  logic [XLEN-1:0] r_regs [NREGS];
  logic [AW-1:0]   w_rs1;
  logic [AW-1:0]   w_rs2;
  logic            w_wr_en;

  assign w_rs1   = instruction[19:15];
  assign w_rs2   = instruction[24:20];
  assign w_wr_en = reg_write && (write_addr != AW'(0));

  // Reset wins over a simultaneous write; x0 is never written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[write_addr] <= write_data;
    end
  end

  // Read port 1: x0 is hardwired to zero, optional forwarding of the in-flight write.
  always_comb begin
    read_data1 = '0;
    if (w_rs1 != AW'(0)) begin
      read_data1 = r_regs[w_rs1];
`ifdef REG_FILE_BYPASS_EN
      if (rst_n && w_wr_en && (write_addr == w_rs1)) begin
        read_data1 = write_data;
      end
`endif
    end
  end

  // Read port 2: same structure as port 1.
  always_comb begin
    read_data2 = '0;
    if (w_rs2 != AW'(0)) begin
      read_data2 = r_regs[w_rs2];
`ifdef REG_FILE_BYPASS_EN
      if (rst_n && w_wr_en && (write_addr == w_rs2)) begin
        read_data2 = write_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed, table-driven bench for reg_file; expectations follow REG_FILE_BYPASS_EN if defined.
module tb_reg_file;

  localparam int unsigned XLEN = 64;
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic            rst_n;
    logic            we;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] exp1;
    logic [XLEN-1:0] exp2;
  } vec_t;

  logic            clk;
  logic            rst_n;
  logic [31:0]     instruction;
  logic            reg_write;
  logic [4:0]      write_addr;
  logic [XLEN-1:0] write_data;
  logic [XLEN-1:0] read_data1;
  logic [XLEN-1:0] read_data2;

  int n_pass;
  int n_total;

  reg_file #(.XLEN(XLEN), .NREGS(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instruction(instruction),
    .reg_write  (reg_write),
    .write_addr (write_addr),
    .write_data (write_data),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // R-type ADD encoding with the requested source registers.
  function automatic logic [31:0] mk_instr(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0000000, rs2, rs1, 3'b000, 5'd1, 7'b0110011};
  endfunction

  function automatic vec_t mkv(input logic r, input logic we, input logic [4:0] wa,
                               input logic [XLEN-1:0] wd, input logic [4:0] a, input logic [4:0] b,
                               input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2);
    vec_t v;
    v.rst_n = r;  v.we = we;  v.waddr = wa;  v.wdata = wd;
    v.rs1 = a;    v.rs2 = b;  v.exp1 = e1;   v.exp2 = e2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Drive one cycle's inputs away from the rising edge; outputs settle 1 unit later.
  task automatic apply(input logic r, input logic we, input logic [4:0] wa,
                       input logic [XLEN-1:0] wd, input logic [4:0] a, input logic [4:0] b);
    @(negedge clk);
    rst_n       = r;
    reg_write   = we;
    write_addr  = wa;
    write_data  = wd;
    instruction = mk_instr(a, b);
    #1;
  endtask

  localparam logic [XLEN-1:0] BEEF = 64'h0000_0000_DEAD_BEEF;
  localparam logic [XLEN-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [XLEN-1:0] NEG3 = 64'hFFFF_FFFF_FFFF_FFFD;

  vec_t vecs [13];

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    reg_write = 1'b0;
    write_addr = '0;
    write_data = '0;
    instruction = '0;

    vecs[0]  = mkv(0, 1, 5'd3, 64'd1234, 5'd0, 5'd0, 64'd0, 64'd0);
    vecs[1]  = mkv(1, 0, 5'd0, 64'd0,    5'd3, 5'd31, 64'd0, 64'd0);
    vecs[2]  = mkv(1, 1, 5'd5, BEEF,     5'd5, 5'd0, BYP ? BEEF : 64'd0, 64'd0);
    vecs[3]  = mkv(1, 0, 5'd5, ONES,     5'd5, 5'd0, BEEF, 64'd0);
    vecs[4]  = mkv(1, 1, 5'd0, ONES,     5'd0, 5'd5, 64'd0, BEEF);
    vecs[5]  = mkv(1, 0, 5'd0, ONES,     5'd0, 5'd5, 64'd0, BEEF);
    vecs[6]  = mkv(1, 1, 5'd7, 64'd1,    5'd7, 5'd7, BYP ? 64'd1 : 64'd0, BYP ? 64'd1 : 64'd0);
    vecs[7]  = mkv(1, 1, 5'd7, 64'd2,    5'd7, 5'd7, BYP ? 64'd2 : 64'd1, BYP ? 64'd2 : 64'd1);
    vecs[8]  = mkv(1, 0, 5'd7, 64'd9,    5'd7, 5'd5, 64'd2, BEEF);
    vecs[9]  = mkv(1, 1, 5'd3, 64'd10,   5'd3, 5'd4, BYP ? 64'd10 : 64'd0, 64'd0);
    vecs[10] = mkv(1, 1, 5'd4, NEG3,     5'd3, 5'd4, 64'd10, BYP ? NEG3 : 64'd0);
    vecs[11] = mkv(1, 0, 5'd4, ONES,     5'd3, 5'd4, 64'd10, NEG3);
    vecs[12] = mkv(1, 0, 5'd31, ONES,    5'd31, 5'd1, 64'd0, 64'd0);

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i].rst_n, vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].rs1, vecs[i].rs2);
      chk($sformatf("vec%0d_rd1", i), read_data1, vecs[i].exp1);
      chk($sformatf("vec%0d_rd2", i), read_data2, vecs[i].exp2);
    end

    // ALU ADD on the read ports: x3 (10) + x4 (-3) = 7.
    apply(1, 0, 5'd0, 64'd0, 5'd3, 5'd4);
    chk("alu_add", read_data1 + read_data2, 64'd7);

    // Fill x1..x31 with 100+i, then read every index back on both ports.
    for (int i = 1; i < 32; i++) begin
      apply(1, 1, 5'(i), XLEN'(100 + i), 5'd0, 5'd0);
    end
    for (int i = 0; i < 32; i++) begin
      apply(1, 0, 5'd0, ONES, 5'(i), 5'(31 - i));
      chk($sformatf("fill_rd1_x%0d", i), read_data1, (i == 0) ? 64'd0 : XLEN'(100 + i));
      chk($sformatf("fill_rd2_x%0d", 31 - i), read_data2, (i == 31) ? 64'd0 : XLEN'(131 - i));
    end

    // Reset mid-program together with a write to x3: everything must clear.
    apply(0, 1, 5'd3, 64'd55, 5'd3, 5'd0);
    for (int i = 0; i < 32; i++) begin
      apply(1, 0, 5'd0, 64'd0, 5'(i), 5'(31 - i));
      chk($sformatf("rst_rd1_x%0d", i), read_data1, 64'd0);
      chk($sformatf("rst_rd2_x%0d", 31 - i), read_data2, 64'd0);
    end

    // Single-register write leaves neighbours alone.
    apply(1, 1, 5'd9, 64'h1234_5678_9ABC_DEF0, 5'd0, 5'd0);
    apply(1, 0, 5'd0, 64'd0, 5'd9, 5'd10);
    chk("single_x9", read_data1, 64'h1234_5678_9ABC_DEF0);
    chk("single_x10", read_data2, 64'd0);
    apply(1, 0, 5'd0, 64'd0, 5'd8, 5'd9);
    chk("single_x8", read_data1, 64'd0);
    chk("same_idx_x9", read_data2, 64'h1234_5678_9ABC_DEF0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
